// File: rtl/crc_check.sv
// Receive-side USB CRC5/CRC16 checker: runs the LFSR over the body including the CRC field,
// forwards the body minus its trailing CRC bits, and reports the residual check when recving falls.
module crc_check #(
  parameter logic [4:0]  CRC5_RESID  = 5'b01100,
  parameter logic [15:0] CRC16_RESID = 16'b1000000000001101
) (
  input  logic clk,
  input  logic rst_L,
  input  logic clear,
  input  logic start,
  input  logic pkttype,
  input  logic inb,
  input  logic in_valid,
  input  logic recving,
  output logic outb,
  output logic out_valid,
  output logic done,
  output logic crc_ok,
  output logic crc_err,
  output logic pkt_short
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

  state_t      state, state_n;
  logic        type16;
  logic [15:0] crc, crc_n, delay;
  logic [4:0]  count, n;
  logic        fb, accept, restart, enter_check, short_now, pass_now;

  assign n = type16 ? 5'd16 : 5'd5;

  always_comb begin
    fb    = 1'b0;
    crc_n = crc;
    if (type16) begin
      fb    = crc[15] ^ inb;
      crc_n = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end else begin
      fb    = crc[4] ^ inb;
      crc_n = {11'd0, crc[3:0], 1'b0} ^ (fb ? 16'h0005 : 16'h0000);
    end
  end

  assign short_now = (count < n);
  assign pass_now  = !short_now &&
                     (type16 ? (crc == CRC16_RESID) : (crc[4:0] == CRC5_RESID));

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    restart     = 1'b0;
    enter_check = 1'b0;
    done        = 1'b0;
    if (clear) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = RECV;
            restart = 1'b1;
          end
        end
        RECV: begin
          if (start) begin
            restart = 1'b1;
          end else if (!recving) begin
            state_n     = CHECK;
            enter_check = 1'b1;
          end else if (in_valid) begin
            accept = 1'b1;
          end
        end
        CHECK: begin
          done    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Bit k leaves the delay line while bit k+N is being accepted.
  assign out_valid = accept && (count >= n);
  assign outb      = out_valid && (type16 ? delay[15] : delay[4]);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_n;
  end

  // Status is captured on the way into CHECK so it is already valid alongside done.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      type16    <= 1'b0;
      crc       <= 16'hFFFF;
      delay     <= 16'd0;
      count     <= 5'd0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      pkt_short <= 1'b0;
    end else if (clear) begin
      crc       <= 16'hFFFF;
      delay     <= 16'd0;
      count     <= 5'd0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      pkt_short <= 1'b0;
    end else begin
      if (restart) begin
        type16    <= pkttype;
        crc       <= 16'hFFFF;
        count     <= 5'd0;
        crc_ok    <= 1'b0;
        crc_err   <= 1'b0;
        pkt_short <= 1'b0;
      end
      if (accept) begin
        crc   <= crc_n;
        delay <= {delay[14:0], inb};
        if (count != 5'd16) count <= count + 5'd1;
      end
      if (enter_check) begin
        pkt_short <= short_now;
        crc_ok    <= pass_now;
        crc_err   <= !pass_now;
      end
    end
  end

endmodule
